fir_out_conditioner: RTL and testbench

//  Downstream stage of the serial FIR filter. Consumes the full-precision accumulator output (y_in, 37b).
//  - Rounds, rescales (Q15 coefficients) and saturates each sample to 16b.
//  - Optionally decimates.
//  - Buffers results in a small FIFO and presents them on a valid/ready stream to the consumer (DAC/logger).

---
 rtl/fir_out_conditioner_pkg.sv | 16 +
 rtl/fir_cond_fifo.sv | 53 +++++
 rtl/fir_out_conditioner.sv | 143 ++++++++++++++
 tb/tb_fir_out_conditioner.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_out_conditioner_pkg.sv
// Shared constants for the FIR output conditioner: default widths, scaling and sizing helpers.
package fir_out_conditioner_pkg;

   localparam int unsigned FIR_IN_WIDTH       = 37;
   localparam int unsigned FIR_OUT_WIDTH      = 16;
   localparam int unsigned FIR_COEF_FRAC      = 15;
   localparam int unsigned FIR_DECIM_DEF      = 1;
   localparam int unsigned FIR_FIFO_DEPTH_DEF = 8;
   localparam int unsigned SATCNT_WIDTH       = 16;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fir_cond_fifo.sv
// Synchronous FIFO for conditioned samples; full/empty derived from the occupancy count.
module fir_cond_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     full,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             rd_ok_c;
   logic             wr_ok_c;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   // A read frees a slot in the same edge, so a full FIFO still accepts a write alongside a read.
   assign rd_ok_c = rd_en && !empty;
   assign wr_ok_c = wr_en && (!full || rd_ok_c);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Sample storage; contents are qualified by level, so no reset is needed.
   always_ff @(posedge clk) begin
      if (wr_ok_c) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_ok_c) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok_c) rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(wr_ok_c) - LW'(rd_ok_c);
      end
   end

endmodule

// File: rtl/fir_out_conditioner.sv
// FIR output conditioner: round, rescale, saturate, decimate and buffer accumulator samples
// onto a valid/ready stream. Define FIR_COND_SATCNT_EN to add the sat_count output.
module fir_out_conditioner
   import fir_out_conditioner_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = FIR_IN_WIDTH,
   parameter int unsigned OUT_WIDTH  = FIR_OUT_WIDTH,
   parameter int unsigned SHIFT      = FIR_COEF_FRAC,
   parameter int unsigned DECIM      = FIR_DECIM_DEF,
   parameter int unsigned FIFO_DEPTH = FIR_FIFO_DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [IN_WIDTH-1:0]           y_in,
   input  logic                          y_valid,
   output logic [OUT_WIDTH-1:0]          out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   input  logic                          clr_flags,
   output logic                          sat_flag,
   output logic                          ovf_flag,
`ifdef FIR_COND_SATCNT_EN
   output logic [SATCNT_WIDTH-1:0]       sat_count,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

   localparam int unsigned SW = IN_WIDTH + 1;
   localparam int unsigned DW = cnt_width(DECIM);
   localparam logic [SW-1:0] RND = SW'(1) << (SHIFT - 1);
   localparam logic signed [SW-1:0] SAT_MAX =
      signed'({{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
   localparam logic signed [SW-1:0] SAT_MIN =
      signed'({{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

   logic signed [SW-1:0]  sum_c;
   logic signed [SW-1:0]  s1_r;
   logic                  s1_valid;
   logic [OUT_WIDTH-1:0]  sat_data_c;
   logic                  clip_c;
   logic [OUT_WIDTH-1:0]  s2_data;
   logic                  s2_valid;
   logic [DW-1:0]         dcnt;
   logic                  sat_evt_c;
   logic                  wr_en_c;
   logic                  drop_c;
   logic                  full;
   logic                  empty;

   // One extra bit of headroom keeps the rounding add from wrapping.
   assign sum_c = $signed({y_in[IN_WIDTH-1], y_in}) + $signed(RND);

   // Stage 1: round half toward +inf and rescale.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_r     <= '0;
      end else begin
         s1_valid <= y_valid;
         s1_r     <= sum_c >>> SHIFT;
      end
   end

   // Clip the rescaled value into the signed output range.
   always_comb begin
      clip_c     = 1'b0;
      sat_data_c = OUT_WIDTH'(s1_r);
      if (s1_r > SAT_MAX) begin
         clip_c     = 1'b1;
         sat_data_c = OUT_WIDTH'(SAT_MAX);
      end else if (s1_r < SAT_MIN) begin
         clip_c     = 1'b1;
         sat_data_c = OUT_WIDTH'(SAT_MIN);
      end
   end

   // Stage 2: register the saturated sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_data  <= sat_data_c;
      end
   end

   // Every sample is checked for clipping; only the first of each DECIM group is buffered.
   assign sat_evt_c = s1_valid && clip_c;
   assign wr_en_c   = s2_valid && (dcnt == '0);
   assign drop_c    = wr_en_c && full && !out_ready;

   // Decimation phase counter over stage-2 samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         dcnt <= '0;
      end else if (s2_valid) begin
         dcnt <= (dcnt == DW'(DECIM - 1)) ? '0 : dcnt + DW'(1);
      end
   end

   // Sticky flags; a new event on the clearing edge keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_flag <= 1'b0;
         ovf_flag <= 1'b0;
      end else begin
         sat_flag <= sat_evt_c || (sat_flag && !clr_flags);
         ovf_flag <= drop_c    || (ovf_flag && !clr_flags);
      end
   end

`ifdef FIR_COND_SATCNT_EN
   // Saturating count of clipped samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_count <= '0;
      end else if (clr_flags) begin
         sat_count <= SATCNT_WIDTH'(sat_evt_c);
      end else if (sat_evt_c && (sat_count != '1)) begin
         sat_count <= sat_count + SATCNT_WIDTH'(1);
      end
   end
`endif

   fir_cond_fifo #(
      .WIDTH (OUT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_c),
      .wr_data (s2_data),
      .full    (full),
      .rd_en   (out_ready),
      .rd_data (out_data),
      .empty   (empty),
      .level   (fill_level)
   );

   assign out_valid = !empty;

endmodule

// File: tb/tb_fir_out_conditioner.sv
// Bench for fir_out_conditioner: two instances (DECIM=1 and DECIM=4) against a queue-based model.
module tb_fir_out_conditioner;

   logic               clk;
   logic               rst;
   logic signed [36:0] y_in;
   logic               y_valid;
   logic               out_ready;
   logic               clr_flags;
   logic [15:0]        od0, od1;
   logic               ov0, ov1, sf0, sf1, of0, of1;
   logic [3:0]         fl0, fl1;
`ifdef FIR_COND_SATCNT_EN
   logic [15:0]        sc0, sc1;
`endif

   int n_pass  = 0;
   int n_total = 0;

   fir_out_conditioner #(.DECIM(1)) u0 (
      .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid),
      .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .clr_flags(clr_flags),
      .sat_flag(sf0), .ovf_flag(of0),
`ifdef FIR_COND_SATCNT_EN
      .sat_count(sc0),
`endif
      .fill_level(fl0)
   );

   fir_out_conditioner #(.DECIM(4)) u1 (
      .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid),
      .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .clr_flags(clr_flags),
      .sat_flag(sf1), .ovf_flag(of1),
`ifdef FIR_COND_SATCNT_EN
      .sat_count(sc1),
`endif
      .fill_level(fl1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input longint got, input longint exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   longint mq [2][$];
   int     mn [2];
   bit     msat [2];
   bit     movf [2];
   bit     model_ok = 1'b0;
   bit     d1v, d2v;
   longint d1y, d2y;

   function automatic longint scaled(input longint y);
      return (y + 16384) >>> 15;
   endfunction

   function automatic longint cond(input longint y);
      longint r;
      r = scaled(y);
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      return r;
   endfunction

   function automatic int decim_of(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   // Inputs change only on the falling edge, so the model sees the same values the DUT samples.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            mn[i]   = 0;
            msat[i] = 1'b0;
            movf[i] = 1'b0;
         end
         d1v = 1'b0;
         d2v = 1'b0;
         model_ok = 1'b1;
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit rd, se, oe, keep;
            rd = out_ready && (mq[i].size() > 0);
            se = d1v && (scaled(d1y) > 32767 || scaled(d1y) < -32768);
            oe = 1'b0;
            if (rd) void'(mq[i].pop_front());
            if (d2v) begin
               keep  = (mn[i] == 0);
               mn[i] = (mn[i] + 1) % decim_of(i);
               if (keep) begin
                  if (mq[i].size() < 8) mq[i].push_back(cond(d2y));
                  else oe = 1'b1;
               end
            end
            msat[i] = se || (msat[i] && !clr_flags);
            movf[i] = oe || (movf[i] && !clr_flags);
         end
         d2v = d1v;
         d2y = d1y;
         d1v = y_valid;
         d1y = longint'(y_in);
      end
   end

   // Compare every cycle once the model has seen reset.
   always @(negedge clk) begin
      if (model_ok) begin
         for (int i = 0; i < 2; i++) begin
            longint exp_dat;
            exp_dat = (mq[i].size() > 0) ? mq[i][0] : 0;
            check($sformatf("u%0d_out_valid", i), (i == 0) ? ov0 : ov1, mq[i].size() > 0);
            check($sformatf("u%0d_out_data", i),
                  (i == 0) ? longint'($signed(od0)) : longint'($signed(od1)), exp_dat);
            check($sformatf("u%0d_fill_level", i), longint'((i == 0) ? fl0 : fl1),
                  longint'(mq[i].size()));
            check($sformatf("u%0d_sat_flag", i), (i == 0) ? sf0 : sf1, msat[i]);
            check($sformatf("u%0d_ovf_flag", i), (i == 0) ? of0 : of1, movf[i]);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic push(input longint y);
      y_in    = 37'(y);
      y_valid = 1'b1;
      @(negedge clk);
      y_valid = 1'b0;
      y_in    = '0;
   endtask

   task automatic single(input longint y, input longint exp, input string nm);
      push(y);
      repeat (2) @(negedge clk);
      check({nm, "_valid"}, ov0, 1);
      check(nm, longint'($signed(od0)), exp);
      @(negedge clk);
   endtask

   longint got [$];

   initial begin
      rst = 1'b1; y_valid = 1'b0; y_in = '0; out_ready = 1'b1; clr_flags = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_valid", ov0, 0);
      check("rst_fill", fl0, 0);
      check("rst_data", longint'($signed(od0)), 0);
      check("rst_flags", {sf0, of0}, 0);

      single(98304, 3, "t1_basic");
      check("t1_sat", sf0, 0);

      single(16384, 1, "t2_p16384");
      single(16383, 0, "t2_p16383");
      single(-16384, 0, "t2_m16384");
      single(-16385, -1, "t2_m16385");

      single(longint'(40000) <<< 15, 32767, "t3_pos");
      check("t3_sat_set", sf0, 1);
      single(-(longint'(40000) <<< 15), -32768, "t3_neg");
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      check("t3_sat_clr", sf0, 0);

      // Decimation by 4 starting from a fresh phase.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      got.delete();
      for (int i = 0; i < 14; i++) begin
         if (ov1) got.push_back(longint'($signed(od1)));
         if (i < 8) begin
            y_in = 37'(longint'(i) <<< 15);
            y_valid = 1'b1;
         end else begin
            y_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("t4_count", got.size(), 2);
      if (got.size() == 2) begin
         check("t4_first", got[0], 0);
         check("t4_second", got[1], 4);
      end

      // Overflow with a stalled consumer, then drain.
      out_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         y_in = 37'(longint'(100 + k) <<< 15);
         y_valid = 1'b1;
         @(negedge clk);
      end
      y_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("t5_fill", fl0, 8);
      check("t5_ovf", of0, 1);
      out_ready = 1'b1;
      got.delete();
      for (int i = 0; i < 12; i++) begin
         if (ov0) got.push_back(longint'($signed(od0)));
         @(negedge clk);
      end
      check("t5_drain_count", got.size(), 8);
      for (int i = 0; i < got.size() && i < 8; i++)
         check($sformatf("t5_drain_%0d", i), got[i], 100 + i);

      // Reset with buffered data discards it in one edge.
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         y_in = (k == 2) ? 37'(longint'(40000) <<< 15) : 37'(longint'(k) <<< 15);
         y_valid = 1'b1;
         @(negedge clk);
      end
      y_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("t6_fill_before", fl0, 5);
      check("t6_sat_before", sf0, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_valid", ov0, 0);
      check("t6_fill", fl0, 0);
      check("t6_flags", {sf0, of0}, 0);
      out_ready = 1'b1;
      single(98304, 3, "t6_restart");
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
